fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues single-beat reads from RESET_PC up to END_PC,
// holds each word for a ready/valid consumer, and follows branch redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] END_PC   = 32'h0000_003C,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        done,
  output logic [15:0] inst_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StValid,
    StDone
  } state_e;

  state_e      state;
  logic [31:0] pc;
  logic        fetch_pend;
  logic        handshake;
  logic [15:0] cnt_inc;

  assign handshake = inst_valid & inst_ready;
  assign cnt_inc   = (inst_cnt == 16'hFFFF) ? inst_cnt : inst_cnt + 16'd1;

  // A redirect arriving in the fetch cycle cancels that read outright, so the
  // refetch in the following cycle never produces back-to-back enables.
  assign mem_ce = fetch_pend & ~redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      pc         <= RESET_PC;
      fetch_pend <= 1'b0;
      mem_addr   <= 32'h0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      inst_cnt   <= 16'h0;
    end else begin
      fetch_pend <= 1'b0;
      case (state)
        StIdle, StDone: begin
          if (start) begin
            state      <= StFetch;
            pc         <= RESET_PC;
            mem_addr   <= RESET_PC;
            fetch_pend <= 1'b1;
            inst_cnt   <= 16'h0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end

        StFetch: begin
          if (redirect) begin
            pc         <= redirect_pc;
            mem_addr   <= redirect_pc;
            fetch_pend <= 1'b1;
          end else begin
            state <= StWait;
          end
        end

        StWait: begin
          if (redirect) begin
            state      <= StFetch;
            pc         <= redirect_pc;
            mem_addr   <= redirect_pc;
            fetch_pend <= 1'b1;
          end else begin
            state      <= StValid;
            inst       <= mem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
          end
        end

        StValid: begin
          if (handshake) begin
            inst_cnt <= cnt_inc;
          end
          if (redirect) begin
            state      <= StFetch;
            inst_valid <= 1'b0;
            pc         <= redirect_pc;
            mem_addr   <= redirect_pc;
            fetch_pend <= 1'b1;
          end else if (handshake) begin
            inst_valid <= 1'b0;
            if (inst_pc == END_PC) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= StFetch;
              pc         <= pc + PC_STEP;
              mem_addr   <= pc + PC_STEP;
              fetch_pend <= 1'b1;
            end
          end
        end

        default: begin
          state      <= StIdle;
          inst_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  a_no_back_to_back_ce : assert property (
    @(posedge clk) disable iff (rst) !(mem_ce && $past(mem_ce))
  );

  a_hold_until_accept : assert property (
    @(posedge clk) disable iff (rst)
    (inst_valid && !inst_ready && !redirect) |=> (inst_valid && $stable(inst) && $stable(inst_pc))
  );

endmodule
